pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage in-order pipeline: decode, readreg, execute, memwrt, regwrt.
- Detects read-after-write hazards between the instruction in readreg and older in-flight writers, then stalls the front end and injects bubbles.
- Freezes the whole pipe while data memory is not ready.
- Flushes decode and readreg on a taken branch resolved in execute.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_cmp.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard sequencer.
package pipeline_pkg;

    localparam int REG_W = 3;

    typedef logic [REG_W-1:0] regnum_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        MEMW  = 2'd2,
        FLUSH = 2'd3
    } hz_state_t;

    // Control word loaded into execute when bubble_s2 is asserted.
    localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_cmp.sv
// hazard_cmp: one readreg source against one older writer stage.
module hazard_cmp
    import pipeline_pkg::*;
#(
    parameter int REGNUM_W = 3
) (
    input  logic                s1_valid,
    input  logic                use_src,
    input  logic [REGNUM_W-1:0] src,
    input  logic                wr,
    input  logic [REGNUM_W-1:0] rd,
    output logic                conflict
);

    // R0 is an ordinary register, so no zero-register exemption here.
    assign conflict = s1_valid & use_src & wr & (src == rd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipe: RAW stalls, memory freeze,
// taken-branch flush and saturating performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REGNUM_W      = 3,
    parameter bit WRITE_THROUGH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s1_valid,
    input  logic [REGNUM_W-1:0] s1_rm,
    input  logic [REGNUM_W-1:0] s1_rn,
    input  logic [REGNUM_W-1:0] s1_rd,
    input  logic                s1_use_rm,
    input  logic                s1_use_rn,
    input  logic                s1_use_rd,
    input  logic                s2_wr,
    input  logic                s3_wr,
    input  logic                s4_wr,
    input  logic [REGNUM_W-1:0] s2_rd,
    input  logic [REGNUM_W-1:0] s3_rd,
    input  logic [REGNUM_W-1:0] s4_rd,
    input  logic                s3_mem_req,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                update_s0,
    output logic                update_s1,
    output logic                bubble_s2,
    output logic                flush_s1,
    output logic                en_s2_s4,
    output logic [1:0]          state_out,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t state, state_nxt;

    logic [REGNUM_W-1:0] src  [3];
    logic                use_ [3];
    logic                wr   [3];
    logic [REGNUM_W-1:0] dst  [3];
    logic                conflict [3][3];

    logic raw_s2, raw_s3, raw_s4, raw, mem_wait;
    logic stall_inc, flush_inc;

    assign src[0]  = s1_rm;
    assign src[1]  = s1_rn;
    assign src[2]  = s1_rd;
    assign use_[0] = s1_use_rm;
    assign use_[1] = s1_use_rn;
    assign use_[2] = s1_use_rd;
    assign wr[0]   = s2_wr;
    assign wr[1]   = s3_wr;
    assign wr[2]   = s4_wr;
    assign dst[0]  = s2_rd;
    assign dst[1]  = s3_rd;
    assign dst[2]  = s4_rd;

    for (genvar k = 0; k < 3; k++) begin : g_stage
        for (genvar i = 0; i < 3; i++) begin : g_src
            hazard_cmp #(.REGNUM_W(REGNUM_W)) u_cmp (
                .s1_valid (s1_valid),
                .use_src  (use_[i]),
                .src      (src[i]),
                .wr       (wr[k]),
                .rd       (dst[k]),
                .conflict (conflict[k][i])
            );
        end
    end

    assign raw_s2 = conflict[0][0] | conflict[0][1] | conflict[0][2];
    assign raw_s3 = conflict[1][0] | conflict[1][1] | conflict[1][2];
    // With a write-through register file, a regwrt writer is already visible.
    assign raw_s4 = (conflict[2][0] | conflict[2][1] | conflict[2][2]) & !WRITE_THROUGH;
    assign raw    = raw_s2 | raw_s3 | raw_s4;

    assign mem_wait = s3_mem_req & !mem_ready;

    // A RAW hidden behind a taken branch causes no stall, since the branch kills it.
    assign stall_inc = mem_wait | (raw & !branch_taken);
    assign flush_inc = branch_taken & !mem_wait;

    assign state_out = state;

    // State register: records the condition decoded in the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Mealy decode of the current-cycle condition; reset forces a safe word.
    always_comb begin
        state_nxt = RUN;
        update_s0 = 1'b1;
        update_s1 = 1'b1;
        bubble_s2 = 1'b0;
        flush_s1  = 1'b0;
        en_s2_s4  = 1'b1;
        if (mem_wait) begin
            state_nxt = MEMW;
            update_s0 = 1'b0;
            update_s1 = 1'b0;
            en_s2_s4  = 1'b0;
        end else if (branch_taken) begin
            state_nxt = FLUSH;
            flush_s1  = 1'b1;
            bubble_s2 = 1'b1;
        end else if (raw) begin
            state_nxt = HAZ;
            update_s0 = 1'b0;
            update_s1 = 1'b0;
            bubble_s2 = 1'b1;
        end
        if (!rst) begin
            update_s0 = 1'b0;
            update_s1 = 1'b0;
            en_s2_s4  = 1'b0;
            bubble_s2 = 1'b1;
            flush_s1  = 1'b1;
        end
    end

    // Saturating stall/freeze cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_inc && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating taken-branch flush counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (flush_inc && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: decode table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s1_valid;
    logic [2:0] s1_rm, s1_rn, s1_rd;
    logic       s1_use_rm, s1_use_rn, s1_use_rd;
    logic       s2_wr, s3_wr, s4_wr;
    logic [2:0] s2_rd, s3_rd, s4_rd;
    logic       s3_mem_req, mem_ready, branch_taken;

    logic        update_s0, update_s1, bubble_s2, flush_s1, en_s2_s4;
    logic [1:0]  state_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        n_update_s0, n_update_s1, n_bubble_s2, n_flush_s1, n_en_s2_s4;
    logic [1:0]  n_state_out;
    logic [3:0]  n_stall_cnt, n_flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REGNUM_W(3), .WRITE_THROUGH(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s1_valid(s1_valid),
        .s1_rm(s1_rm), .s1_rn(s1_rn), .s1_rd(s1_rd),
        .s1_use_rm(s1_use_rm), .s1_use_rn(s1_use_rn), .s1_use_rd(s1_use_rd),
        .s2_wr(s2_wr), .s3_wr(s3_wr), .s4_wr(s4_wr),
        .s2_rd(s2_rd), .s3_rd(s3_rd), .s4_rd(s4_rd),
        .s3_mem_req(s3_mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .update_s0(update_s0), .update_s1(update_s1), .bubble_s2(bubble_s2),
        .flush_s1(flush_s1), .en_s2_s4(en_s2_s4), .state_out(state_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.REGNUM_W(3), .WRITE_THROUGH(1'b1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .s1_valid(s1_valid),
        .s1_rm(s1_rm), .s1_rn(s1_rn), .s1_rd(s1_rd),
        .s1_use_rm(s1_use_rm), .s1_use_rn(s1_use_rn), .s1_use_rd(s1_use_rd),
        .s2_wr(s2_wr), .s3_wr(s3_wr), .s4_wr(s4_wr),
        .s2_rd(s2_rd), .s3_rd(s3_rd), .s4_rd(s4_rd),
        .s3_mem_req(s3_mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .update_s0(n_update_s0), .update_s1(n_update_s1), .bubble_s2(n_bubble_s2),
        .flush_s1(n_flush_s1), .en_s2_s4(n_en_s2_s4), .state_out(n_state_out),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [2:0] rm, rn, rd;
        logic       um, un, ud;
        logic       w2;
        logic [2:0] d2;
        logic       w3;
        logic [2:0] d3;
        logic       w4;
        logic [2:0] d4;
        logic       mreq, mrdy, br;
        logic [4:0] exp;  // {update_s0, update_s1, bubble_s2, flush_s1, en_s2_s4}
    } vec_t;

    vec_t vecs[16];

    function automatic logic [4:0] ctl();
        return {update_s0, update_s1, bubble_s2, flush_s1, en_s2_s4};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        s1_valid = 0; s1_rm = 0; s1_rn = 0; s1_rd = 0;
        s1_use_rm = 0; s1_use_rn = 0; s1_use_rd = 0;
        s2_wr = 0; s3_wr = 0; s4_wr = 0; s2_rd = 0; s3_rd = 0; s4_rd = 0;
        s3_mem_req = 0; mem_ready = 1; branch_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    function automatic vec_t mk(input string name, input logic v,
                                input logic [2:0] rm, input logic um,
                                input logic [2:0] rn, input logic un,
                                input logic [2:0] rd, input logic ud,
                                input logic w2, input logic [2:0] d2,
                                input logic w3, input logic [2:0] d3,
                                input logic w4, input logic [2:0] d4,
                                input logic mreq, input logic mrdy, input logic br,
                                input logic [4:0] exp);
        vec_t t;
        t.name = name; t.v = v; t.rm = rm; t.um = um; t.rn = rn; t.un = un;
        t.rd = rd; t.ud = ud; t.w2 = w2; t.d2 = d2; t.w3 = w3; t.d3 = d3;
        t.w4 = w4; t.d4 = d4; t.mreq = mreq; t.mrdy = mrdy; t.br = br; t.exp = exp;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             name        v  rm um rn un rd ud w2 d2 w3 d3 w4 d4 mq mr br  exp
        vecs[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
        vecs[1]  = mk("raw_s2_rm", 1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 5'b00101);
        vecs[2]  = mk("raw_s3_rn", 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 5'b00101);
        vecs[3]  = mk("raw_s3_rd", 1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 6, 0, 0, 0, 1, 0, 5'b00101);
        vecs[4]  = mk("s4_wthru",  1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0, 5'b11001);
        vecs[5]  = mk("no_use",    1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
        vecs[6]  = mk("s1_inval",  0, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
        vecs[7]  = mk("r0_raw",    1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00101);
        vecs[8]  = mk("no_wr",     1, 3, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
        vecs[9]  = mk("reg_diff",  1, 3, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
        vecs[10] = mk("branch",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111);
        vecs[11] = mk("mem_wait",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000);
        vecs[12] = mk("mem_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11001);
        vecs[13] = mk("mw_br_raw", 1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 1, 5'b00000);
        vecs[14] = mk("br_raw",    1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 5'b11111);
        vecs[15] = mk("nordy_noreq",0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001);

        idle();
        rst = 0;
        #2;
        chk("rst_ctl", int'(ctl()), int'(5'b00110));
        chk("rst_state", int'(state_out), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk("rst_flush", int'(flush_cnt), 0);
        @(negedge clk);
        rst = 1;

        // Combinational decode table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s1_valid = vecs[i].v;
            s1_rm = vecs[i].rm; s1_use_rm = vecs[i].um;
            s1_rn = vecs[i].rn; s1_use_rn = vecs[i].un;
            s1_rd = vecs[i].rd; s1_use_rd = vecs[i].ud;
            s2_wr = vecs[i].w2; s2_rd = vecs[i].d2;
            s3_wr = vecs[i].w3; s3_rd = vecs[i].d3;
            s4_wr = vecs[i].w4; s4_rd = vecs[i].d4;
            s3_mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            branch_taken = vecs[i].br;
            #1;
            chk(vecs[i].name, int'(ctl()), int'(vecs[i].exp));
        end

        // Writer R3 walks execute -> memwrt -> regwrt: two stall cycles
        do_reset();
        s1_valid = 1; s1_rm = 3; s1_use_rm = 1; s2_wr = 1; s2_rd = 3;
        #1 chk("t1_c0_ctl", int'(ctl()), int'(5'b00101));
        @(negedge clk);
        chk("t1_c0_state", int'(state_out), 1);
        s2_wr = 0; s3_wr = 1; s3_rd = 3;
        #1 chk("t1_c1_ctl", int'(ctl()), int'(5'b00101));
        @(negedge clk);
        s3_wr = 0; s4_wr = 1; s4_rd = 3;
        #1 chk("t1_c2_ctl", int'(ctl()), int'(5'b11001));
        @(negedge clk);
        chk("t1_state", int'(state_out), 0);
        chk("t1_stall", int'(stall_cnt), 2);

        // Same walk, source not read
        do_reset();
        s1_valid = 1; s1_rm = 3; s1_use_rm = 0; s2_wr = 1; s2_rd = 3;
        #1 chk("t2_c0_ctl", int'(ctl()), int'(5'b11001));
        @(negedge clk);
        s2_wr = 0; s3_wr = 1; s3_rd = 3;
        #1 chk("t2_c1_ctl", int'(ctl()), int'(5'b11001));
        @(negedge clk);
        chk("t2_stall", int'(stall_cnt), 0);
        chk("t2_state", int'(state_out), 0);

        // Branch with RAW present
        do_reset();
        s1_valid = 1; s1_rm = 3; s1_use_rm = 1; s2_wr = 1; s2_rd = 3; branch_taken = 1;
        #1 chk("t3_ctl", int'(ctl()), int'(5'b11111));
        @(negedge clk);
        idle();
        chk("t3_state", int'(state_out), 3);
        chk("t3_flush", int'(flush_cnt), 1);
        chk("t3_stall", int'(stall_cnt), 0);
        @(negedge clk);
        chk("t3_back_run", int'(state_out), 0);

        // Memory freeze holds a pending branch
        do_reset();
        s3_mem_req = 1; mem_ready = 0; branch_taken = 1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_freeze_en", int'(en_s2_s4), 0);
            @(negedge clk);
        end
        chk("t4_state", int'(state_out), 2);
        chk("t4_stall", int'(stall_cnt), 3);
        chk("t4_flush0", int'(flush_cnt), 0);
        mem_ready = 1;
        #1 chk("t4_rdy_ctl", int'(ctl()), int'(5'b11111));
        @(negedge clk);
        chk("t4_flush1", int'(flush_cnt), 1);
        chk("t4_state_fl", int'(state_out), 3);
        chk("t4_stall_hold", int'(stall_cnt), 3);

        // Asynchronous reset between edges while frozen
        idle();
        s3_mem_req = 1; mem_ready = 0;
        @(negedge clk);
        chk("t5_pre_state", int'(state_out), 2);
        #2 rst = 0;
        #1;
        chk("t5_state", int'(state_out), 0);
        chk("t5_stall", int'(stall_cnt), 0);
        chk("t5_flush", int'(flush_cnt), 0);
        chk("t5_ctl", int'(ctl()), int'(5'b00110));
        @(negedge clk);
        idle();
        rst = 1;
        #1 chk("t5_rel_ctl", int'(ctl()), int'(5'b11001));
        @(negedge clk);
        chk("t5_rel_state", int'(state_out), 0);

        // Saturation of the 4-bit counter
        do_reset();
        s1_valid = 1; s1_rn = 7; s1_use_rn = 1; s2_wr = 1; s2_rd = 7;
        repeat (20) @(negedge clk);
        chk("t6_sat4", int'(n_stall_cnt), 15);
        chk("t6_cnt16", int'(stall_cnt), 20);
        chk("t6_state4", int'(n_state_out), 1);
        chk("t6_flush4", int'(n_flush_cnt), 0);
        chk("t6_ctl4", int'({n_update_s0, n_update_s1, n_bubble_s2, n_flush_s1, n_en_s2_s4}),
            int'(5'b00101));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
